// File: rtl/tl_pkg.sv
// Shared definitions for the traffic light command path: command codes,
// payload widths and the error codes reported by the link deframer.
package tl_pkg;

  localparam int CMD_W  = 3;
  localparam int DATA_W = 16;

  typedef enum logic [CMD_W-1:0] {
    ON              = 3'd0,
    OFF             = 3'd1,
    TO_NOTRANSITION = 3'd2,
    GREEN_SET       = 3'd3,
    RED_SET         = 3'd4,
    YELLOW_SET      = 3'd5
  } command_t;

  localparam logic [1:0] ERR_CSUM    = 2'd0;
  localparam logic [1:0] ERR_TYPE    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // A raw type byte names a command only if it fits the command_t range.
  function automatic logic is_known_cmd(input logic [7:0] code);
    return code <= {5'd0, YELLOW_SET};
  endfunction

endpackage

// File: rtl/tl_byte_timeout.sv
// Inter-byte idle timer for link parsers. Counts clocks while enabled and
// not cleared; expired pulses on the clock where the count reaches the limit.
// A limit of 0 disables the timer entirely.
module tl_byte_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Fires when this clock would carry the count onto the limit; a clear in
  // the same cycle (a byte arriving) always wins.
  assign expired = (TIMEOUT_CYCLES != 0) && enable && !clear && (count == LAST);

  // Idle counter: cleared on demand, saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use <= so every flop samples pre-edge values; blocking
    // assignments here would create order-dependent simulation races.
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (TIMEOUT_CYCLES != 0) && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tl_cmd_deframer.sv
// Parses SOF/TYPE/DHI/DLO/CSUM frames from the host byte link into
// single-cycle command strobes for the traffic light controller, and reports
// checksum, type and inter-byte timeout errors with a saturating counter.
module tl_cmd_deframer
  import tl_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned ERR_CNT_W      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           data_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  output logic [CMD_W-1:0]     cmd_type_o,
  output logic                 cmd_valid_o,
  output logic [DATA_W-1:0]    cmd_data_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TYPE = 3'd1;
  localparam logic [2:0] S_DHI  = 3'd2;
  localparam logic [2:0] S_DLO  = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;

  logic [2:0]        state;
  logic [7:0]        type_q;
  logic [DATA_W-1:0] data_q;
  logic [7:0]        csum_q;

  logic       accept;
  logic       tmo_fire;
  logic       frame_done;
  logic       csum_ok;
  logic       cmd_fire;
  logic       err_fire;
  logic [1:0] err_code_next;

  assign accept = data_valid_i && data_ready_o;

  tl_byte_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (accept || (state == S_IDLE)),
    .enable  (state != S_IDLE),
    .expired (tmo_fire)
  );

  // Decide what the end of this cycle reports: a command, an error, or nothing.
  always_comb begin
    // NOTE: every signal gets a value before any condition so no path can
    // leave one unassigned and infer a latch.
    frame_done    = accept && (state == S_CSUM);
    csum_ok       = (data_i == csum_q);
    cmd_fire      = frame_done && csum_ok && is_known_cmd(type_q);
    err_fire      = (frame_done && !cmd_fire) || tmo_fire;
    err_code_next = ERR_CSUM;
    if (tmo_fire) begin
      err_code_next = ERR_TIMEOUT;
    end else if (csum_ok) begin
      err_code_next = ERR_TYPE;
    end
  end

  // Frame FSM: one state per accepted byte, abandoned on timeout.
  // An SOF value inside a frame is plain data; there is no resync.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      type_q <= '0;
      data_q <= '0;
      csum_q <= '0;
    end else if (accept) begin
      case (state)
        S_IDLE: if (data_i == SOF_BYTE) state <= S_TYPE;
        S_TYPE: begin
          type_q <= data_i;
          csum_q <= data_i;
          state  <= S_DHI;
        end
        S_DHI: begin
          data_q[DATA_W-1:8] <= data_i;
          csum_q             <= csum_q ^ data_i;
          state              <= S_DLO;
        end
        S_DLO: begin
          data_q[7:0] <= data_i;
          csum_q      <= csum_q ^ data_i;
          state       <= S_CSUM;
        end
        default: state <= S_IDLE;
      endcase
    end else if (tmo_fire) begin
      state <= S_IDLE;
    end
  end

  // Registered strobes, held command/error fields and saturating error count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_ready_o <= 1'b0;
      cmd_valid_o  <= 1'b0;
      cmd_type_o   <= '0;
      cmd_data_o   <= '0;
      err_o        <= 1'b0;
      err_code_o   <= '0;
      err_cnt_o    <= '0;
    end else begin
      data_ready_o <= 1'b1;
      cmd_valid_o  <= cmd_fire;
      err_o        <= err_fire;
      if (cmd_fire) begin
        cmd_type_o <= type_q[CMD_W-1:0];
        cmd_data_o <= data_q;
      end
      if (err_fire) begin
        err_code_o <= err_code_next;
        if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/tl_cmd_deframer.md
Name: tl_cmd_deframer

Overview:
Upstream command source for the traffic light controller. Parses a byte stream from the host link (UART/bridge) into framed commands. Drives the controller's cmd_type/cmd_valid/cmd_data inputs with single-cycle pulses. Detects checksum, type and inter-byte timeout errors, reports each with an error pulse and a saturating error count.

Parameters:
SOF_BYTE, 8'hA5, start-of-frame marker.
TIMEOUT_CYCLES, 1000, max idle clocks between bytes inside a frame; 0 disables the timeout.
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset; asynchronous, active-high.
data_i  in  8  incoming byte.
data_valid_i  in  1  byte qualifier.
data_ready_o  out  1  byte accept; a byte is consumed when data_valid_i && data_ready_o.
cmd_type_o  out  3  command code, command_t encoding.
cmd_valid_o  out  1  single-cycle command strobe.
cmd_data_o  out  16  command payload, MSB first on the link.
err_o  out  1  single-cycle error strobe.
err_code_o  out  2  0 = checksum, 1 = bad type, 2 = timeout; valid with err_o.
err_cnt_o  out  ERR_CNT_W  saturating count of errors since reset.

Behaviour:
- Reset values (asynchronous, active-high): state IDLE. data_ready_o 0 while rst_i is high, 1 from the first clock after release and always 1 thereafter. All other outputs 0.
- Frame format: SOF, TYPE, DHI, DLO, CSUM. CSUM = TYPE ^ DHI ^ DLO.
- FSM states: IDLE, TYPE, DHI, DLO, CSUM. Each accepted byte advances one state.
- IDLE: accepted byte == SOF_BYTE goes to TYPE. Any other byte is discarded silently with no error.
- TYPE: latches the byte. DHI and DLO latch the payload. CSUM compares the accepted byte against the running XOR, then returns to IDLE.
- Checksum match and TYPE in 0..5: next clock drives cmd_valid_o=1 for exactly one cycle, with cmd_type_o=TYPE[2:0] and cmd_data_o={DHI,DLO}. Latency is 1 clock after the CSUM byte is accepted.
- Checksum mismatch: err_o pulse, code 0, no command.
- Checksum match but TYPE > 5 (any upper bit set, or value 6/7): err_o pulse, code 1, no command.
- Errors are registered with the same 1-clock latency as commands. cmd_valid_o and err_o never assert together.
- An SOF_BYTE value inside a frame is treated as ordinary data. There is no mid-frame resync.
- Timeout counter: cleared on every accepted byte and while in IDLE; increments each clock otherwise.
  - When it reaches TIMEOUT_CYCLES in a non-IDLE state: FSM returns to IDLE, err_o pulse with code 2, partial frame discarded.
  - A byte accepted in the same cycle the timeout would fire wins: the byte is processed and the counter clears.
- cmd_type_o and cmd_data_o hold their last command values between strobes. err_code_o holds its last value.
- err_cnt_o increments by 1 on each err_o and saturates at 2^ERR_CNT_W-1 with no wrap.
- The timeout counter is sized $clog2(TIMEOUT_CYCLES+1) bits. All comparisons are unsigned.
- Reset asserted mid-frame: partial frame and pending strobe are discarded immediately; no strobe is emitted after release.

Decomposition:
- Shared package tl_pkg holds:
  - command_t enum: ON=0, OFF=1, TO_NOTRANSITION=2, GREEN_SET=3, RED_SET=4, YELLOW_SET=5.
  - CMD_W=3 and DATA_W=16.
  - Error-code localparams ERR_CSUM, ERR_TYPE, ERR_TIMEOUT.
- The traffic light controller imports command_t from tl_pkg as well.
- One natural sub-module: tl_byte_timeout (load/clear, enable, expired), reusable by other link parsers.

Test Plan:
- A5 03 01 23 21 -> one clock after the last byte: cmd_valid_o=1 for 1 cycle, cmd_type_o=3, cmd_data_o=16'h0123, err_o=0.
- A5 00 00 00 00 preceded by junk 11 22 -> exactly one ON command with data 0, no error, err_cnt_o=0.
- A5 04 00 0A 0F (correct CSUM is 0E) -> err_o=1 with code 0, no cmd_valid_o, err_cnt_o=1. A following valid frame is still decoded.
- A5 07 00 05 02 (checksum correct) -> err_o with code 1, no command.
- TIMEOUT_CYCLES=10: A5 03 then a 10-clock gap -> err_o code 2 on the 10th idle clock. A byte on exactly that clock instead continues the frame with no error.
- rst_i asserted asynchronously between DHI and DLO, then released and DLO/CSUM sent -> no command, outputs 0. Also: 300 bad frames -> err_cnt_o stops at 255.
